// File: rtl/player_hit_detector_pkg.sv
// Shared game definitions for the player hit detector: FSM states and
// bit positions inside the reported hit_source field.
package player_hit_detector_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } hit_state_t;

    localparam int HIT_SRC_W       = 2;
    localparam int HIT_SRC_MISSILE = 0;
    localparam int HIT_SRC_ENEMY   = 1;

endpackage

// File: rtl/player_hit_detector_if.sv
// Pixel draw requests into the hit detector and its hit reports out.
// master = video/draw side, slave = detector.
interface player_hit_detector_if;
    import player_hit_detector_pkg::*;

    logic                 startOfFrame;
    logic                 player_draw;
    logic                 missile_draw;
    logic                 enemy_draw;
    logic                 missile_collision;
    logic                 missile_hit;
    logic [HIT_SRC_W-1:0] hit_source;
    logic                 cooling_down;

    modport master (
        output startOfFrame, player_draw, missile_draw, enemy_draw,
        input  missile_collision, missile_hit, hit_source, cooling_down
    );

    modport slave (
        input  startOfFrame, player_draw, missile_draw, enemy_draw,
        output missile_collision, missile_hit, hit_source, cooling_down
    );

endinterface

// File: rtl/player_hit_detector_saturating_counter.sv
// Up/down counter that sticks at all-ones going up and at zero going down.
// Load has priority over clear, clear over counting.
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX_VAL)) begin
            count <= count + ONE;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/player_hit_detector.sv
// Counts player/missile/enemy overlap pixels per frame and, at each frame
// boundary, reports at most one hit to the lives tracker, followed by a cooldown.
module player_hit_detector
    import player_hit_detector_pkg::*;
#(
    parameter int OVERLAP_WIDTH     = 8,
    parameter int OVERLAP_THRESHOLD = 4,
    parameter int COOLDOWN_WIDTH    = 6,
    parameter int COOLDOWN_FRAMES   = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    player_hit_detector_if.slave  bus
);

    localparam logic [OVERLAP_WIDTH-1:0]  THRESH  = OVERLAP_WIDTH'(OVERLAP_THRESHOLD);
    localparam logic [COOLDOWN_WIDTH-1:0] CD_LOAD = COOLDOWN_WIDTH'(COOLDOWN_FRAMES);
    localparam logic [COOLDOWN_WIDTH-1:0] CD_LAST = COOLDOWN_WIDTH'(1);

    hit_state_t                state, state_next;
    logic                      sof_p0;
    logic                      missile_ov_p0;
    logic                      enemy_ov_p0;
    logic                      overlap_p0;
    logic                      fire;
    logic                      cd_load;
    logic                      cd_dec;
    logic                      saw_missile;
    logic                      saw_enemy;
    logic [OVERLAP_WIDTH-1:0]  overlap_count;
    logic [COOLDOWN_WIDTH-1:0] cooldown;
    logic                      missile_collision_p1;
    logic                      missile_hit_p1;
    logic [HIT_SRC_W-1:0]      hit_source_p1;

    assign sof_p0        = bus.startOfFrame;
    assign missile_ov_p0 = bus.player_draw & bus.missile_draw;
    assign enemy_ov_p0   = bus.player_draw & bus.enemy_draw;
    assign overlap_p0    = missile_ov_p0 | enemy_ov_p0;

    // The startOfFrame pixel opens the new frame, so it loads rather than adds.
    saturating_counter #(.WIDTH(OVERLAP_WIDTH)) u_overlap_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clr      (1'b0),
        .load     (sof_p0),
        .load_val (OVERLAP_WIDTH'(overlap_p0)),
        .inc      (overlap_p0),
        .dec      (1'b0),
        .count    (overlap_count)
    );

    saturating_counter #(.WIDTH(COOLDOWN_WIDTH)) u_cooldown_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .clr      (1'b0),
        .load     (cd_load),
        .load_val (CD_LOAD),
        .inc      (1'b0),
        .dec      (cd_dec),
        .count    (cooldown)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ARMED;
        end else begin
            state <= state_next;
        end
    end

    // The boundary that ends cooldown is not itself evaluated.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        cd_load    = 1'b0;
        cd_dec     = 1'b0;
        case (state)
            ARMED: begin
                if (sof_p0 && (overlap_count >= THRESH)) begin
                    fire       = 1'b1;
                    cd_load    = 1'b1;
                    state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (sof_p0) begin
                    cd_dec = 1'b1;
                    if (cooldown == CD_LAST) begin
                        state_next = ARMED;
                    end
                end
            end
            default: state_next = ARMED;
        endcase
    end

    // Stage p0 -> p1: per-frame flags and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            saw_missile          <= 1'b0;
            saw_enemy            <= 1'b0;
            missile_collision_p1 <= 1'b0;
            missile_hit_p1       <= 1'b0;
            hit_source_p1        <= '0;
        end else begin
            if (sof_p0) begin
                saw_missile <= missile_ov_p0;
                saw_enemy   <= enemy_ov_p0;
            end else begin
                saw_missile <= saw_missile | missile_ov_p0;
                saw_enemy   <= saw_enemy | enemy_ov_p0;
            end
            missile_collision_p1 <= fire;
            missile_hit_p1       <= missile_ov_p0;
            if (fire) begin
                hit_source_p1[HIT_SRC_MISSILE] <= saw_missile;
                hit_source_p1[HIT_SRC_ENEMY]   <= saw_enemy;
            end
        end
    end

    assign bus.missile_collision = missile_collision_p1;
    assign bus.missile_hit       = missile_hit_p1;
    assign bus.hit_source        = hit_source_p1;
    assign bus.cooling_down      = (state == COOLDOWN);

endmodule

// File: tb/tb_player_hit_detector.sv
// Scoreboard bench: two detectors (threshold 4 and threshold 1) share stimulus;
// a behavioural model pushes expected outputs that are popped one cycle later.
module tb_player_hit_detector;

    localparam int OW  = 8;
    localparam int CW  = 6;
    localparam int CF  = 10;
    localparam int CMAX = 255;

    typedef struct packed {
        logic       coll;
        logic       hit;
        logic [1:0] src;
        logic       cool;
    } exp_t;

    logic clk;
    logic resetN;

    player_hit_detector_if bus0 ();
    player_hit_detector_if bus1 ();

    player_hit_detector #(
        .OVERLAP_WIDTH(OW), .OVERLAP_THRESHOLD(4),
        .COOLDOWN_WIDTH(CW), .COOLDOWN_FRAMES(CF)
    ) dut0 (
        .clk(clk), .resetN(resetN), .bus(bus0)
    );

    player_hit_detector #(
        .OVERLAP_WIDTH(OW), .OVERLAP_THRESHOLD(1),
        .COOLDOWN_WIDTH(CW), .COOLDOWN_FRAMES(CF)
    ) dut1 (
        .clk(clk), .resetN(resetN), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];

    int       m_cnt  [2];
    bit       m_sm   [2];
    bit       m_se   [2];
    bit       m_cool [2];
    int       m_cd   [2];
    bit [1:0] m_src  [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_sm[k] = 0; m_se[k] = 0;
            m_cool[k] = 0; m_cd[k] = 0; m_src[k] = 2'b00;
        end
    endtask

    task automatic model_step(input int k, input bit sof, input bit p, input bit m,
                              input bit e, output exp_t x);
        int thr;
        bit ov;
        thr = (k == 0) ? 4 : 1;
        ov  = p & (m | e);
        x.coll = 1'b0;
        if (sof) begin
            if (!m_cool[k]) begin
                if (m_cnt[k] >= thr) begin
                    x.coll    = 1'b1;
                    m_src[k]  = {m_se[k], m_sm[k]};
                    m_cool[k] = 1;
                    m_cd[k]   = CF;
                end
            end else begin
                if (m_cd[k] == 1) m_cool[k] = 0;
                m_cd[k] = m_cd[k] - 1;
            end
            m_cnt[k] = ov ? 1 : 0;
            m_sm[k]  = p & m;
            m_se[k]  = p & e;
        end else begin
            if (ov && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
            m_sm[k] = m_sm[k] | (p & m);
            m_se[k] = m_se[k] | (p & e);
        end
        x.hit  = p & m;
        x.src  = m_src[k];
        x.cool = m_cool[k];
    endtask

    task automatic compare_one(input string who, input exp_t x, input logic coll,
                               input logic hit, input logic [1:0] src, input logic cool);
        check({who, ".collision"}, {7'd0, coll}, {7'd0, x.coll});
        check({who, ".missile_hit"}, {7'd0, hit}, {7'd0, x.hit});
        check({who, ".hit_source"}, {6'd0, src}, {6'd0, x.src});
        check({who, ".cooling_down"}, {7'd0, cool}, {7'd0, x.cool});
    endtask

    task automatic step(input bit rn, input bit sof, input bit p, input bit m, input bit e);
        exp_t x0, x1;
        @(negedge clk);
        resetN = rn;
        bus0.startOfFrame = sof; bus0.player_draw = p; bus0.missile_draw = m; bus0.enemy_draw = e;
        bus1.startOfFrame = sof; bus1.player_draw = p; bus1.missile_draw = m; bus1.enemy_draw = e;
        if (!rn) begin
            model_reset();
            x0 = '0;
            x1 = '0;
        end else begin
            model_step(0, sof, p, m, e, x0);
            model_step(1, sof, p, m, e, x1);
        end
        q0.push_back(x0);
        q1.push_back(x1);
        @(posedge clk);
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            x0 = q0.pop_front();
            x1 = q1.pop_front();
            compare_one("d0", x0, bus0.missile_collision, bus0.missile_hit,
                        bus0.hit_source, bus0.cooling_down);
            compare_one("d1", x1, bus1.missile_collision, bus1.missile_hit,
                        bus1.hit_source, bus1.cooling_down);
        end
    endtask

    // One frame: opening sof (no overlap), then n_ov separated overlap pixels.
    task automatic frame(input int len, input int n_ov, input bit m, input bit e);
        step(1, 1, 0, 0, 0);
        for (int i = 1; i < len; i++) begin
            if ((i % 2 == 1) && (i / 2 < n_ov)) step(1, 0, 1, m, e);
            else                                step(1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        resetN = 1'b0;
        bus0.startOfFrame = 0; bus0.player_draw = 0; bus0.missile_draw = 0; bus0.enemy_draw = 0;
        bus1.startOfFrame = 0; bus1.player_draw = 0; bus1.missile_draw = 0; bus1.enemy_draw = 0;
        model_reset();

        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0);

        // 3 missile pixels below threshold, then 5 that qualify
        frame(12, 3, 1, 0);
        frame(12, 5, 1, 0);
        // ten cooldown frames of overlap, then one more that reports
        for (int f = 0; f < 10; f++) frame(12, 5, 1, 0);
        frame(12, 5, 1, 0);
        for (int f = 0; f < 12; f++) frame(2, 0, 0, 0);

        // enemy-body-only overlap long enough to saturate the counter
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 1, 0, 1);
        check("overlap_saturated", dut0.overlap_count, 8'd255);
        for (int f = 0; f < 12; f++) frame(2, 0, 0, 0);

        // single overlap on the startOfFrame pixel only
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // reset in the middle of a frame with 4 overlap pixels already counted
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/player_hit_detector.md
# player_hit_detector

Upstream of the player lives tracker. Watches the per-pixel draw requests of the player ship, enemy missiles and enemy bodies across each video frame, and counts overlapping pixels. At each frame boundary it decides whether a real hit occurred and issues one registered `missile_collision` pulse to the lives tracker. A per-pixel `missile_hit` strobe tells the missile block which missile to remove.

## Interface
- `OVERLAP_WIDTH`, 8: width of the per-frame overlap pixel counter.
- `OVERLAP_THRESHOLD`, 4: minimum overlapping pixels in one frame that count as a hit; legal range 1..2^OVERLAP_WIDTH-1.
- `COOLDOWN_WIDTH`, 6: width of the post-hit cooldown frame counter.
- `COOLDOWN_FRAMES`, 32: number of frame boundaries ignored after a reported hit; must be ≥1.

- `clk` in 1: pixel clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse marking the first pixel of a frame.
- `player_draw` in 1: the player ship is drawing the current pixel.
- `missile_draw` in 1: an enemy missile is drawing the current pixel.
- `enemy_draw` in 1: an enemy body is drawing the current pixel.
- `missile_collision` out 1: one-cycle hit pulse to the lives tracker.
- `missile_hit` out 1: registered `player_draw & missile_draw`, one cycle after the pixel.
- `hit_source` out 2: bit0 = missile overlap, bit1 = enemy-body overlap, for the last reported hit.
- `cooling_down` out 1: high while in COOLDOWN.

## Operation
- Overlap pixel = `player_draw & (missile_draw | enemy_draw)`.
- `overlap_count` is a saturating counter and holds at all-ones. It increments once per overlap pixel.
- Per-frame sticky flags `saw_missile` and `saw_enemy` set on the respective overlap.
- FSM states:
  - ARMED: at `startOfFrame`, if `overlap_count ≥ OVERLAP_THRESHOLD`:
    - pulse `missile_collision`
    - latch `hit_source` from the flags
    - load cooldown with `COOLDOWN_FRAMES`
    - go to COOLDOWN
  - COOLDOWN: counting and `missile_hit` continue. Hit evaluation is suppressed. Each `startOfFrame` decrements cooldown. When cooldown is 1 at a `startOfFrame`, it returns to ARMED; that same boundary is not evaluated.
- On every `startOfFrame`, the counter and flags restart for the new frame in both states. The `startOfFrame` pixel itself belongs to the new frame: counter loads 1 if that pixel overlaps, else 0.
- `missile_hit` is independent of the FSM, so missiles are always consumed even during cooldown.
- Reset, which may arrive mid-frame, leaves the block with:
  - state ARMED
  - counter, flags and cooldown 0
  - all outputs 0, including `hit_source` = 2'b00
  - the partial frame discarded

## Timing
- `missile_collision` rises the cycle after the `startOfFrame` that closes the qualifying frame and is high for exactly one cycle.
- `missile_hit` has 1-cycle latency from the pixel.
- `hit_source` updates on the same edge as the `missile_collision` rise and holds until the next reported hit.
- Evaluation uses the count accumulated through the cycle before `startOfFrame`.
- All outputs are registered. There is no combinational path from inputs to outputs.
- With no `startOfFrame`, the block never reports; the count saturates and holds.

## Structure
- A shared game package holds:
  - the FSM enum `hit_state_t` (ARMED, COOLDOWN)
  - the `hit_source` bit-position constants
- Sub-module `saturating_counter` (parameterized width, clear/load/inc) is natural. It is instantiated twice: overlap counter and cooldown counter with decrement.

## Test plan
- Missile overlap for 3 pixels in a frame with threshold 4, then `startOfFrame`:
  - no `missile_collision`
  - `missile_hit` pulses 3 times, each 1 cycle late
- Missile overlap for 5 pixels, then `startOfFrame`:
  - `missile_collision` high for exactly 1 cycle, the cycle after `startOfFrame`
  - `hit_source` = 2'b01
  - `cooling_down` = 1
- After that hit, 10 frames each with 5 missile overlap pixels:
  - no further pulse
  - `missile_hit` keeps pulsing
  - the first boundary after the cooldown expires gives no report
  - the next overlapping frame reports
- Enemy-body-only overlap of 300 pixels with `OVERLAP_WIDTH` = 8:
  - counter saturates at 255
  - report with `hit_source` = 2'b10
- Overlap on the `startOfFrame` cycle only (1 pixel), with threshold 1:
  - the pixel counts toward the new frame
  - report at the following boundary, not the current one
- `resetN` low mid-frame after 4 overlap pixels, released, then `startOfFrame`:
  - no report
  - all outputs 0 during reset and after
